// File: rtl/usb_tx_line_encoder.sv
// USB full/low-speed transmit line encoder: NRZI coding, bit stuffing after six
// consecutive ones, and SE0/SE0/J end-of-packet generation on registered D+/D- drives.
module usb_tx_line_encoder (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic bit_last,
    output logic bit_ready,
    output logic dp,
    output logic dm,
    output logic tx_active
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        STUFF = 3'd2,
        EOP1  = 3'd3,
        EOP2  = 3'd4,
        EOPJ  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       act_q, act_d;
    logic       lvl_q, lvl_d;    // current NRZI level, 1 = J
    logic       last_q, last_d;  // bit that triggered a stuff was the packet's last
    logic [2:0] cnt_q, cnt_d;

    logic       accept;
    logic       nrzi_lvl;
    logic [2:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
            act_q   <= 1'b0;
            lvl_q   <= 1'b1;
            last_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            act_q   <= act_d;
            lvl_q   <= lvl_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bit_ready = (state_q == IDLE) || (state_q == DATA);
        accept    = bit_valid && bit_ready;
        nrzi_lvl  = bit_in ? lvl_q : ~lvl_q;
        cnt_inc   = bit_in ? (cnt_q + 3'd1) : 3'd0;

        state_d = state_q;
        dp_d    = dp_q;
        dm_d    = dm_q;
        act_d   = act_q;
        lvl_d   = lvl_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    lvl_d  = nrzi_lvl;
                    dp_d   = nrzi_lvl;
                    dm_d   = ~nrzi_lvl;
                    act_d  = 1'b1;
                    cnt_d  = cnt_inc;
                    last_d = bit_last;
                    // Sixth consecutive one: a stuffed zero must follow before anything else.
                    if (bit_in && (cnt_q == 3'd5)) begin
                        state_d = STUFF;
                    end else if (bit_last) begin
                        state_d = EOP1;
                    end else begin
                        state_d = DATA;
                    end
                end else if (state_q == IDLE) begin
                    dp_d  = 1'b1;
                    dm_d  = 1'b0;
                    act_d = 1'b0;
                    lvl_d = 1'b1;
                    cnt_d = 3'd0;
                end else begin
                    act_d = 1'b1;
                end
            end
            STUFF: begin
                lvl_d   = ~lvl_q;
                dp_d    = ~lvl_q;
                dm_d    = lvl_q;
                act_d   = 1'b1;
                cnt_d   = 3'd0;
                state_d = last_q ? EOP1 : DATA;
            end
            EOP1, EOP2: begin
                dp_d    = 1'b0;
                dm_d    = 1'b0;
                act_d   = 1'b1;
                lvl_d   = 1'b1;
                cnt_d   = 3'd0;
                state_d = (state_q == EOP1) ? EOP2 : EOPJ;
            end
            EOPJ: begin
                dp_d    = 1'b1;
                dm_d    = 1'b0;
                act_d   = 1'b1;
                lvl_d   = 1'b1;
                cnt_d   = 3'd0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dp        = dp_q;
    assign dm        = dm_q;
    assign tx_active = act_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: expected {dp,dm,tx_active} per cycle are
// queued ahead of each scenario and popped as the registered outputs update.
module tb_usb_tx_line_encoder;

    logic clk;
    logic rst;
    logic bit_in;
    logic bit_valid;
    logic bit_last;
    logic bit_ready;
    logic dp;
    logic dm;
    logic tx_active;

    usb_tx_line_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_last  (bit_last),
        .bit_ready (bit_ready),
        .dp        (dp),
        .dm        (dm),
        .tx_active (tx_active)
    );

    // {dp, dm, tx_active}
    localparam logic [2:0] JA = 3'b101;
    localparam logic [2:0] KA = 3'b011;
    localparam logic [2:0] SA = 3'b001;
    localparam logic [2:0] JI = 3'b100;

    logic [2:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic pushn(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    // er < 0 skips the bit_ready check for this cycle
    task automatic step(input logic v, input logic b, input logic l, input logic r,
                        input int er, input string tag);
        logic [2:0] e;
        rst       = r;
        bit_valid = v;
        bit_in    = b;
        bit_last  = l;
        if (er >= 0) chk({tag, "_ready"}, {2'b00, bit_ready}, er[2:0]);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {dp, dm, tx_active}, e);
        end
        total++;
        assert (!(dp && dm)) else begin
            bad++;
            $error("FAIL %s_se1 observed=%b%b expected=not11", tag, dp, dm);
        end
    endtask

    initial begin
        logic [7:0] sync;
        sync      = 8'b1000_0000;
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        bit_last  = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        pushn(JI, 2);
        step(1'b0, 1'b0, 1'b0, 1'b1, -1, "reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "idle");

        // SYNC pattern
        pushn(KA, 1); pushn(JA, 1); pushn(KA, 1); pushn(JA, 1);
        pushn(KA, 1); pushn(JA, 1); pushn(KA, 1); pushn(KA, 1);
        pushn(SA, 2); pushn(JA, 1); pushn(JI, 1);
        for (int i = 0; i < 8; i++)
            step(1'b1, sync[i], (i == 7), 1'b0, 1, "sync_bit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "sync_eop1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "sync_eop2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "sync_eopj");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "sync_idle");

        // 0 then seven ones, stuff mid-packet; garbage offered during the stuff cycle
        pushn(KA, 7); pushn(JA, 2); pushn(SA, 2); pushn(JA, 1); pushn(JI, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1, "s7_zero");
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1, "s7_one");
        step(1'b1, 1'b0, 1'b1, 1'b0, 0, "s7_stuff");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1, "s7_last");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s7_eop1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s7_eop2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s7_eopj");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "s7_idle");

        // six ones, sixth last: stuff precedes EOP
        pushn(JA, 6); pushn(KA, 1); pushn(SA, 2); pushn(JA, 1); pushn(JI, 1);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, (i == 5), 1'b0, 1, "s6_one");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s6_stuff");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s6_eop1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s6_eop2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "s6_eopj");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "s6_idle");

        // underrun gap after five ones; counter must survive the gap
        pushn(JA, 9); pushn(KA, 1); pushn(JA, 1); pushn(SA, 2); pushn(JA, 1); pushn(JI, 1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1, "gap_one");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1, "gap_hold");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1, "gap_sixth");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "gap_stuff");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1, "gap_last");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "gap_eop1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "gap_eop2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "gap_eopj");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "gap_idle");

        // reset during EOP1, then a single-bit 0 packet from reference J
        pushn(KA, 1); pushn(JI, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1, "rse_bit");
        step(1'b0, 1'b0, 1'b0, 1'b1, 0, "rse_reset");
        pushn(KA, 1); pushn(SA, 2); pushn(JA, 1); pushn(JI, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1, "one_bit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "one_eop1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "one_eop2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 0, "one_eopj");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "one_idle");

        // reset during DATA abandons the packet without EOP
        pushn(KA, 1); pushn(JI, 2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1, "rsd_bit");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1, "rsd_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1, "rsd_idle");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
